// File: rtl/inv_response_checker.sv
// inv_response_checker
//   Sequential response checker for a bank of WIDTH CMOS inverters.
//   Each run drives a latched pattern onto dut_in and waits SETTLE_CYCLES
//   clocks. It then checks every lane of dut_out for exact inversion,
//   reports the per-lane mismatches and bumps a saturating pass or fail counter.
//
//   Optional build macro: INV_CHK_STICKY_EN adds sticky_err, a per-lane
//   record of any mismatch since the last rst or cnt_clr.
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous active-high reset, aborts any run in flight
//   start      request a run, only accepted in IDLE
//   pattern    test vector, latched when start is accepted
//   cnt_clr    synchronous clear of pass_cnt/fail_cnt (and sticky_err)
//   dut_in     registered drive to the inverter inputs
//   dut_out    inverter outputs returned from the bank
//   busy       high from start acceptance until the result edge
//   done       one-cycle pulse, results valid while high
//   pass       1 when every lane was the exact inverse of dut_in
//   err_mask   per-lane mismatch flags from the last run
//   pass_cnt   saturating count of passing runs
//   fail_cnt   saturating count of failing runs
//   sticky_err (INV_CHK_STICKY_EN only) OR of err_mask since last clear
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; the done cycle is also an IDLE cycle
// SETTLE | dut_in driven, settle down-counter runs to terminal count 0
// CHECK  | dut_out sampled; results registered on the edge leaving it
module inv_response_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] err_mask,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef INV_CHK_STICKY_EN
  ,
  output logic [WIDTH-1:0] sticky_err
`endif
);

  // A one-cycle settle still needs a 1-bit counter to hold its load value.
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SCW-1:0]   settle_cnt;
  logic             accept;
  logic             result;
  logic [WIDTH-1:0] err_now;
  logic             pass_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    result    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = CHECK;
      end
      CHECK: begin
        result    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Case-equality compare so an X or Z lane in simulation is a mismatch
  // rather than propagating X into err_mask.
  always_comb begin
    err_now = '0;
    for (int i = 0; i < WIDTH; i++) begin
      err_now[i] = (dut_out[i] === ~dut_in[i]) ? 1'b0 : 1'b1;
    end
  end

  assign pass_now = (err_now == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= '0;
      settle_cnt <= '0;
    end else begin
      done <= result;
      if (accept) begin
        dut_in     <= pattern;
        busy       <= 1'b1;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (result) begin
        busy     <= 1'b0;
        pass     <= pass_now;
        err_mask <= err_now;
      end
    end
  end

  // Clear takes priority over a coincident result update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (cnt_clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (result) begin
      if (pass_now) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

`ifdef INV_CHK_STICKY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sticky_err <= '0;
    else if (cnt_clr) sticky_err <= '0;
    else if (result)  sticky_err <= sticky_err | err_now;
  end
`endif

endmodule

// File: tb/tb_inv_response_checker.sv
// Directed bench for inv_response_checker. u0 uses the default parameters
// with a fault-injectable inverter bank; u1 (CNT_W=2) sees the same stimulus
// with a good bank and is used for the saturation checks.
module tb_inv_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       cnt_clr;
  logic [3:0] pattern;
  logic       stuck2;
  logic       float0;

  wire  [3:0] dut_in0;
  wire  [3:0] dut_out0;
  logic       busy0, done0, pass0;
  logic [3:0] err0;
  logic [7:0] pc0, fc0;

  wire  [3:0] dut_in1;
  wire  [3:0] dut_out1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [1:0] pc1, fc1;
`ifdef INV_CHK_STICKY_EN
  logic [3:0] st0, st1;
`endif

  // Inverter bank models. Lane 0 of u0 can float; it is tested with an
  // input of 0 so the float is a mismatch whether it stays Z or resolves low.
  assign dut_out0[3] = ~dut_in0[3];
  assign dut_out0[2] = stuck2 ? 1'b0 : ~dut_in0[2];
  assign dut_out0[1] = ~dut_in0[1];
  assign dut_out0[0] = float0 ? 1'bz : ~dut_in0[0];
  assign dut_out1    = ~dut_in1;

  inv_response_checker #(.WIDTH(4), .SETTLE_CYCLES(3), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .cnt_clr(cnt_clr),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .pass(pass0), .err_mask(err0), .pass_cnt(pc0), .fail_cnt(fc0)
`ifdef INV_CHK_STICKY_EN
    , .sticky_err(st0)
`endif
  );

  inv_response_checker #(.WIDTH(4), .SETTLE_CYCLES(3), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .cnt_clr(cnt_clr),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .pass(pass1), .err_mask(err1), .pass_cnt(pc1), .fail_cnt(fc1)
`ifdef INV_CHK_STICKY_EN
    , .sticky_err(st1)
`endif
  );

  int npass  = 0;
  int ntotal = 0;
  int lat;
  int ndone;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run, confirm the latch, then wait (bounded) for done.
  // Returns edges from acceptance to the done edge, or -1 on timeout.
  task automatic run(input logic [3:0] pat, output int l);
    start   = 1'b1;
    pattern = pat;
    tick();
    start = 1'b0;
    check("dut_in_latch", 32'(dut_in0), 32'(pat));
    check("busy_set", 32'(busy0), 32'd1);
    l = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done0) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cnt_clr = 1'b0; pattern = 4'h0;
    stuck2 = 1'b0; float0 = 1'b0;
    tick();
    tick();
    check("rst_dut_in", 32'(dut_in0), 32'd0);
    check("rst_busy",   32'(busy0),   32'd0);
    check("rst_done",   32'(done0),   32'd0);
    check("rst_pass",   32'(pass0),   32'd0);
    check("rst_err",    32'(err0),    32'd0);
    check("rst_pc",     32'(pc0),     32'd0);
    check("rst_fc",     32'(fc0),     32'd0);
    rst = 1'b0;
    tick();

    // good bank
    run(4'b1010, lat);
    check("good_lat",  32'(lat),   32'd4);
    check("good_pass", 32'(pass0), 32'd1);
    check("good_err",  32'(err0),  32'd0);
    check("good_pc",   32'(pc0),   32'd1);
    check("good_fc",   32'(fc0),   32'd0);
    check("good_busy", 32'(busy0), 32'd0);
    tick();
    check("done_pulse", 32'(done0), 32'd0);
    check("pass_hold",  32'(pass0), 32'd1);

    // lane 2 stuck low
    stuck2 = 1'b1;
    run(4'b0000, lat);
    check("stuck_lat",  32'(lat),      32'd4);
    check("stuck_out",  32'(dut_out0), 32'b1011);
    check("stuck_pass", 32'(pass0),    32'd0);
    check("stuck_err",  32'(err0),     32'b0100);
    check("stuck_fc",   32'(fc0),      32'd1);
    check("stuck_pc",   32'(pc0),      32'd1);
`ifdef INV_CHK_STICKY_EN
    check("stuck_sticky", 32'(st0), 32'b0100);
`endif
    stuck2 = 1'b0;

    run(4'b0101, lat);
    check("good2_pass", 32'(pass0), 32'd1);
    check("good2_err",  32'(err0),  32'd0);
    check("good2_pc",   32'(pc0),   32'd2);
`ifdef INV_CHK_STICKY_EN
    check("sticky_hold", 32'(st0), 32'b0100);
`endif

    // floating lane 0
    float0 = 1'b1;
    run(4'b1110, lat);
    check("float_err",  32'(err0), 32'b0001);
    check("float_pass", 32'(pass0), 32'd0);
    check("float_fc",   32'(fc0),  32'd2);
    float0 = 1'b0;

    run(4'b0011, lat);
    check("good3_pc", 32'(pc0), 32'd3);

    // start while busy is ignored and pattern not resampled
    start = 1'b1; pattern = 4'b1100;
    tick();
    start = 1'b0;
    check("busy_latch", 32'(dut_in0), 32'b1100);
    tick();
    start = 1'b1; pattern = 4'b0000;
    tick();
    start = 1'b0;
    check("busy_ignore_in", 32'(dut_in0), 32'b1100);
    check("busy_still",     32'(busy0),   32'd1);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done0) begin
        lat = k;
        break;
      end
    end
    check("busy_run_lat", 32'(lat), 32'd2);
    check("busy_run_pc",  32'(pc0), 32'd4);
    check("sat_pc",       32'(pc1), 32'd3);
    check("sat_fc",       32'(fc1), 32'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done0) ndone++;
    end
    check("no_queued_run", 32'(ndone), 32'd0);

    // cnt_clr coinciding with the result edge
    start = 1'b1; pattern = 4'b1001;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_done", 32'(done0), 32'd1);
    check("clr_pc",   32'(pc0),   32'd0);
    check("clr_fc",   32'(fc0),   32'd0);
    check("clr_pass", 32'(pass0), 32'd1);
    check("clr_pc1",  32'(pc1),   32'd0);
`ifdef INV_CHK_STICKY_EN
    check("clr_sticky", 32'(st0), 32'd0);
`endif

    // throughput: start held for 50 edges after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; pattern = 4'b0110;
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done0) ndone++;
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done0) ndone++;
    end
    check("thru_done", 32'(ndone), 32'd10);
    check("thru_pc",   32'(pc0),   32'd10);
    check("thru_fc",   32'(fc0),   32'd0);
    check("thru_pc1",  32'(pc1),   32'd3);

    // reset mid-run during SETTLE
    start = 1'b1; pattern = 4'b1010;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("mid_dut_in", 32'(dut_in0), 32'd0);
    check("mid_busy",   32'(busy0),   32'd0);
    check("mid_pass",   32'(pass0),   32'd0);
    check("mid_pc",     32'(pc0),     32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done0) ndone++;
    end
    check("mid_no_done", 32'(ndone), 32'd0);
    run(4'b0110, lat);
    check("post_lat",  32'(lat),   32'd4);
    check("post_pass", 32'(pass0), 32'd1);
    check("post_pc",   32'(pc0),   32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
